// File: rtl/ysyx_22050078_wb_sched_pkg.sv
// Shared definitions for the writeback scheduler.
// Holds the register-file geometry defaults and the arbiter grant encoding.
package ysyx_22050078_wb_sched_pkg;

  localparam int unsigned REG_ADDRW = 5;   // register address width (32 registers)
  localparam int unsigned CPU_WIDTH = 64;  // register data width

  // Identifies which requester most recently won a contested arbitration.
  typedef enum logic {
    GrantExu = 1'b0,
    GrantLsu = 1'b1
  } grant_e;

endpackage

// File: rtl/ysyx_22050078_rr_arb2.sv
// Two-way round-robin arbiter between the EXU and LSU writeback requesters.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_valid_exu    EXU requests the write port
//   i_valid_lsu    LSU requests the write port
//   o_grant_exu    one-hot grant to EXU (combinational)
//   o_grant_lsu    one-hot grant to LSU (combinational)
module ysyx_22050078_rr_arb2
  import ysyx_22050078_wb_sched_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid_exu,
  input  logic i_valid_lsu,
  output logic o_grant_exu,
  output logic o_grant_lsu
);

  grant_e r_last_grant;
  logic   w_both;

  assign w_both = i_valid_exu && i_valid_lsu;

  always_comb begin
    o_grant_exu = 1'b0;
    o_grant_lsu = 1'b0;
    if (w_both) begin
      // Contested: the requester that did not win the previous contest goes first.
      o_grant_exu = (r_last_grant == GrantLsu);
      o_grant_lsu = (r_last_grant == GrantExu);
    end else begin
      o_grant_exu = i_valid_exu;
      o_grant_lsu = i_valid_lsu;
    end
  end

  // Only contested cycles move the round-robin pointer; an uncontested grant leaves it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= GrantLsu;
    end else if (w_both) begin
      r_last_grant <= o_grant_exu ? GrantExu : GrantLsu;
    end
  end

endmodule

// File: rtl/ysyx_22050078_wb_sched.sv
// Writeback scheduler and scoreboard for a single-write-port register file.
// Ports:
//   i_clk, i_rst                      clock and synchronous active-high reset
//   i_issue_valid/i_issue_rd          decode issues an instruction writing rd
//   o_issue_ready                     issue accepted (rd counter not saturated)
//   i_rs1_addr/i_rs2_addr, o_stall    source operands and RAW stall toward decode
//   i_exu_*/o_exu_ready               EXU writeback request and grant
//   i_lsu_*/o_lsu_ready               LSU writeback request and grant
//   o_rf_wen/o_rf_waddr/o_rf_wdata    registered register-file write port
module ysyx_22050078_wb_sched
  import ysyx_22050078_wb_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDRW,
  parameter int unsigned DATA_WIDTH = CPU_WIDTH,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_issue_valid,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  output logic                  o_issue_ready,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
  output logic                  o_stall,
  input  logic                  i_exu_valid,
  input  logic [ADDR_WIDTH-1:0] i_exu_rd,
  input  logic [DATA_WIDTH-1:0] i_exu_data,
  output logic                  o_exu_ready,
  input  logic                  i_lsu_valid,
  input  logic [ADDR_WIDTH-1:0] i_lsu_rd,
  input  logic [DATA_WIDTH-1:0] i_lsu_data,
  output logic                  o_lsu_ready,
  output logic                  o_rf_wen,
  output logic [ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic                  w_gnt_exu;
  logic                  w_gnt_lsu;
  logic                  w_wb_hs;
  logic [ADDR_WIDTH-1:0] w_wb_rd;
  logic [DATA_WIDTH-1:0] w_wb_data;
  logic                  w_issue_hs;
  logic [NumRegs-1:0]    w_inc;
  logic [NumRegs-1:0]    w_dec;
  logic [CNT_WIDTH-1:0]  w_cnt_d [NumRegs];
  logic [CNT_WIDTH-1:0]  r_cnt   [NumRegs];
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  ysyx_22050078_rr_arb2 u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid_exu (i_exu_valid),
    .i_valid_lsu (i_lsu_valid),
    .o_grant_exu (w_gnt_exu),
    .o_grant_lsu (w_gnt_lsu)
  );

  assign o_exu_ready = w_gnt_exu;
  assign o_lsu_ready = w_gnt_lsu;
  assign w_wb_hs     = w_gnt_exu || w_gnt_lsu;
  assign w_wb_rd     = w_gnt_exu ? i_exu_rd : i_lsu_rd;
  assign w_wb_data   = w_gnt_exu ? i_exu_data : i_lsu_data;

  assign o_issue_ready = !((i_issue_rd != '0) && (r_cnt[i_issue_rd] == {CNT_WIDTH{1'b1}}));
  assign w_issue_hs    = i_issue_valid && o_issue_ready;

  assign o_stall = ((i_rs1_addr != '0) && (r_cnt[i_rs1_addr] != '0)) ||
                   ((i_rs2_addr != '0) && (r_cnt[i_rs2_addr] != '0));

  // Retirement is keyed off the registered port so the counter hits zero on the
  // same edge the register file captures the value.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issue_hs && (i_issue_rd != '0)) begin
      w_inc[i_issue_rd] = 1'b1;
    end
    if (r_wen) begin
      w_dec[r_waddr] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      w_cnt_d[i] = r_cnt[i];
      if (i != 0) begin
        if (w_inc[i] && !w_dec[i]) begin
          w_cnt_d[i] = r_cnt[i] + CNT_WIDTH'(1);
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          w_cnt_d[i] = r_cnt[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        // Retiring a register with nothing pending is an upstream protocol error.
        assert (!(w_dec[i] && !w_inc[i] && (r_cnt[i] == '0)));
      end
      r_cnt <= w_cnt_d;
    end
  end

  // x0 writebacks complete the handshake but never reach the register file;
  // address and data hold when nothing is written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_wb_hs && (w_wb_rd != '0);
      if (w_wb_hs && (w_wb_rd != '0)) begin
        r_waddr <= w_wb_rd;
        r_wdata <= w_wb_data;
      end
    end
  end

  assign o_rf_wen   = r_wen;
  assign o_rf_waddr = r_waddr;
  assign o_rf_wdata = r_wdata;

endmodule

// File: tb/tb_ysyx_22050078_wb_sched.sv
module tb_ysyx_22050078_wb_sched;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        o_issue_ready;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_stall;
  logic        i_exu_valid;
  logic [4:0]  i_exu_rd;
  logic [63:0] i_exu_data;
  logic        o_exu_ready;
  logic        i_lsu_valid;
  logic [4:0]  i_lsu_rd;
  logic [63:0] i_lsu_data;
  logic        o_lsu_ready;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [63:0] o_rf_wdata;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  ysyx_22050078_wb_sched dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .o_issue_ready (o_issue_ready),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_stall       (o_stall),
    .i_exu_valid   (i_exu_valid),
    .i_exu_rd      (i_exu_rd),
    .i_exu_data    (i_exu_data),
    .o_exu_ready   (o_exu_ready),
    .i_lsu_valid   (i_lsu_valid),
    .i_lsu_rd      (i_lsu_rd),
    .i_lsu_data    (i_lsu_data),
    .o_lsu_ready   (o_lsu_ready),
    .o_rf_wen      (o_rf_wen),
    .o_rf_waddr    (o_rf_waddr),
    .o_rf_wdata    (o_rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    i_issue_valid = 1'b1;
    i_issue_rd    = rd;
    tick();
    i_issue_valid = 1'b0;
  endtask

  // EXU handshake cycle followed by the retire cycle.
  task automatic wb_exu(input logic [4:0] rd, input logic [63:0] data);
    i_exu_valid = 1'b1;
    i_exu_rd    = rd;
    i_exu_data  = data;
    tick();
    i_exu_valid = 1'b0;
    tick();
  endtask

  initial begin
    i_rst = 1'b1;
    i_issue_valid = 1'b0; i_issue_rd = '0;
    i_rs1_addr = '0; i_rs2_addr = '0;
    i_exu_valid = 1'b0; i_exu_rd = '0; i_exu_data = '0;
    i_lsu_valid = 1'b0; i_lsu_rd = '0; i_lsu_data = '0;
    tick();
    tick();
    i_rst = 1'b0;
    i_issue_rd = 5'd5;
    #1;
    chk("rst_wen", o_rf_wen, 0);
    chk("rst_waddr", o_rf_waddr, 0);
    chk("rst_wdata", o_rf_wdata, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_issue_ready", o_issue_ready, 1);
    chk("rst_exu_ready", o_exu_ready, 0);
    chk("rst_lsu_ready", o_lsu_ready, 0);

    // Pending write on x5 stalls a reader of x5.
    issue(5'd5);
    i_rs1_addr = 5'd5;
    #1;
    chk("raw_stall_x5", o_stall, 1);

    // EXU writeback: one-cycle write latency, stall clears the cycle after.
    i_exu_valid = 1'b1; i_exu_rd = 5'd5; i_exu_data = 64'hDEAD;
    #1;
    chk("exu_only_exu_ready", o_exu_ready, 1);
    chk("exu_only_lsu_ready", o_lsu_ready, 0);
    tick();
    i_exu_valid = 1'b0;
    #1;
    chk("wb5_wen", o_rf_wen, 1);
    chk("wb5_waddr", o_rf_waddr, 5);
    chk("wb5_wdata", o_rf_wdata, 64'hDEAD);
    chk("wb5_stall_still", o_stall, 1);
    tick();
    chk("wb5_stall_clear", o_stall, 0);
    chk("wb5_wen_drop", o_rf_wen, 0);
    chk("wb5_waddr_hold", o_rf_waddr, 5);
    i_rs1_addr = '0;

    // Contested arbitration alternates, starting with EXU.
    issue(5'd3); issue(5'd3); issue(5'd4); issue(5'd4);
    i_exu_valid = 1'b1; i_exu_rd = 5'd3; i_exu_data = 64'h33;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd4; i_lsu_data = 64'h44;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_exu_ready", o_exu_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_lsu_ready", o_lsu_ready, (k % 2 == 1) ? 1 : 0);
      tick();
      chk("rr_wen", o_rf_wen, 1);
      chk("rr_waddr", o_rf_waddr, (k % 2 == 0) ? 3 : 4);
      chk("rr_wdata", o_rf_wdata, (k % 2 == 0) ? 64'h33 : 64'h44);
    end
    i_exu_valid = 1'b0; i_lsu_valid = 1'b0;
    i_rs1_addr = 5'd3; i_rs2_addr = 5'd4;
    #1;
    chk("rr_stall_before_last", o_stall, 1);
    tick();
    chk("rr_stall_after", o_stall, 0);
    i_rs1_addr = '0; i_rs2_addr = '0;

    // Saturation of x7 at three outstanding writes.
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sat_ready_ok", o_issue_ready, 1);
      tick();
    end
    #1;
    chk("sat_ready_full", o_issue_ready, 0);
    tick();
    chk("sat_ready_held", o_issue_ready, 0);
    i_issue_valid = 1'b0;
    i_exu_valid = 1'b1; i_exu_rd = 5'd7; i_exu_data = 64'h77;
    tick();
    i_exu_valid = 1'b0;
    #1;
    chk("sat_ready_retire_cycle", o_issue_ready, 0);
    tick();
    chk("sat_ready_again", o_issue_ready, 1);
    i_rs1_addr = 5'd7;
    wb_exu(5'd7, 64'h77);
    chk("sat_stall_cnt1", o_stall, 1);
    wb_exu(5'd7, 64'h77);
    chk("sat_stall_cnt0", o_stall, 0);
    i_rs1_addr = '0;

    // Issue and retire of x9 in the same cycle leave its count unchanged.
    issue(5'd9);
    i_rs2_addr = 5'd9;
    i_exu_valid = 1'b1; i_exu_rd = 5'd9; i_exu_data = 64'h99;
    tick();
    i_exu_valid = 1'b0;
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    #1;
    chk("same_wen", o_rf_wen, 1);
    chk("same_waddr", o_rf_waddr, 9);
    chk("same_issue_ready", o_issue_ready, 1);
    tick();
    i_issue_valid = 1'b0;
    #1;
    chk("same_stall_kept", o_stall, 1);
    wb_exu(5'd9, 64'h99);
    chk("same_stall_clear", o_stall, 0);

    // x0 writeback: handshake completes, port stays quiet and holds.
    i_rs1_addr = 5'd5;
    i_exu_valid = 1'b1; i_exu_rd = 5'd0; i_exu_data = 64'h1234;
    #1;
    chk("x0_exu_ready", o_exu_ready, 1);
    tick();
    i_exu_valid = 1'b0;
    #1;
    chk("x0_wen", o_rf_wen, 0);
    chk("x0_waddr_hold", o_rf_waddr, 9);
    chk("x0_wdata_hold", o_rf_wdata, 64'h99);
    chk("x0_stall", o_stall, 0);

    // Reset with a granted writeback in flight.
    issue(5'd10);
    i_rs1_addr = 5'd10; i_rs2_addr = '0;
    #1;
    chk("rst2_stall_before", o_stall, 1);
    i_exu_valid = 1'b1; i_exu_rd = 5'd10; i_exu_data = 64'hAA;
    #1;
    chk("rst2_exu_ready", o_exu_ready, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_exu_valid = 1'b0;
    #1;
    chk("rst2_wen", o_rf_wen, 0);
    chk("rst2_waddr", o_rf_waddr, 0);
    chk("rst2_wdata", o_rf_wdata, 0);
    chk("rst2_stall", o_stall, 0);

    // After reset the first contested grant goes to EXU again.
    i_exu_valid = 1'b1; i_exu_rd = '0;
    i_lsu_valid = 1'b1; i_lsu_rd = '0;
    #1;
    chk("rst2_tie_exu", o_exu_ready, 1);
    chk("rst2_tie_lsu", o_lsu_ready, 0);
    i_exu_valid = 1'b0; i_lsu_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050078_wb_sched.md
Name: ysyx_22050078_wb_sched

Overview:
Writeback scheduler and scoreboard for the single-write-port, 32 x 64-bit integer register file.
- Arbitrates between two writeback requesters, EXU (ALU results) and LSU (load data), onto the one register-file write port.
- Tracks outstanding destination writes per register and raises a read-after-write stall toward decode.
- Sits between the EXU/LSU stages and the register file's write port (wen/waddr/wdata).

Parameters:
- ADDR_WIDTH, 5, register address width (32 registers).
- DATA_WIDTH, 64, register data width.
- CNT_WIDTH, 2, per-register pending-write counter width; maximum 2^CNT_WIDTH-1 outstanding writes per register.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_issue_valid  in  1  decode issues an instruction that writes rd.
- i_issue_rd  in  ADDR_WIDTH  destination of the issued instruction.
- o_issue_ready  out  1  issue accepted this cycle.
- i_rs1_addr  in  ADDR_WIDTH  decode source 1.
- i_rs2_addr  in  ADDR_WIDTH  decode source 2.
- o_stall  out  1  source operand has a pending write.
- i_exu_valid  in  1  EXU writeback request.
- i_exu_rd  in  ADDR_WIDTH  EXU destination.
- i_exu_data  in  DATA_WIDTH  EXU result.
- o_exu_ready  out  1  EXU request granted.
- i_lsu_valid  in  1  LSU writeback request.
- i_lsu_rd  in  ADDR_WIDTH  LSU destination.
- i_lsu_data  in  DATA_WIDTH  LSU load data.
- o_lsu_ready  out  1  LSU request granted.
- o_rf_wen  out  1  register file write enable.
- o_rf_waddr  out  ADDR_WIDTH  register file write address.
- o_rf_wdata  out  DATA_WIDTH  register file write data.

Behaviour:
- Reset (i_rst=1 at a posedge): all pending counters=0; last_grant=LSU, so EXU wins the first tie; o_rf_wen=0; o_rf_waddr=0; o_rf_wdata=0.
- Reset mid-operation discards any granted-but-unwritten result and all pending state.
- Arbitration (combinational grant):
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin; grant the requester not granted last, then update last_grant.
  - o_*_ready=1 only for the granted requester; handshake = valid && ready.
  - Requesters must hold valid, rd and data stable until ready.
- Write port registered, 1-cycle latency: handshake in cycle N gives o_rf_wen=1 with that rd/data in cycle N+1; the register file captures at the end of N+1.
- No handshake in cycle N gives o_rf_wen=0 in N+1; waddr/wdata hold their previous values.
- rd=0 writeback: handshake still completes, but o_rf_wen=0 and no counter changes. x0 is never written and never pending.
- Scoreboard, one CNT_WIDTH counter per register 1..31:
  - Increment on issue handshake (i_issue_valid && o_issue_ready, rd!=0).
  - Decrement in the cycle o_rf_wen=1 for that address, so the counter reaches 0 on the same edge the value lands in the register file.
  - Issue and retire of the same rd in the same cycle: counter unchanged.
- o_issue_ready = !(i_issue_rd!=0 && cnt[i_issue_rd]==max). Saturation stalls issue; it never wraps.
- A decrement when the counter is 0 is a protocol violation: the simulation assertion fires and the counter stays 0.
- o_stall = (rs1!=0 && cnt[rs1]!=0) || (rs2!=0 && cnt[rs2]!=0). Combinational; there is no bypass, and the stall clears the cycle after o_rf_wen.
- Upstream guarantees that writes to any one rd retire in issue order (WAW ordering is not enforced here).

Decomposition:
- Shared defines (existing defines file): REG_ADDRW, CPU_WIDTH, REG_COUNT.
- Sub-module ysyx_22050078_rr_arb2: 2-way round-robin arbiter holding last_grant, with valid inputs and one-hot grant outputs.
- Scoreboard counters and the registered write port stay in the top block.

Test Plan:
- Reset, then idle:
  - Required: o_rf_wen=0, o_stall=0, o_issue_ready=1.
  - Issue rd=5; drive rs1=5 next cycle. Required: o_stall=1.
- EXU write (rd=5, data=0xDEAD) handshake in cycle N:
  - Required: o_rf_wen=1, waddr=5, wdata=0xDEAD in N+1.
  - Required: o_stall for rs1=5 is 0 in N+2.
- EXU and LSU both valid for 4 cycles (rd=3 and rd=4):
  - Required: grants alternate EXU, LSU, EXU, LSU.
  - Required: exactly one ready per cycle and waddr sequence 3,4,3,4.
- Issue rd=7 three times, then a fourth issue:
  - Required: o_issue_ready=0 on the fourth; counter holds 3.
  - After one writeback to 7, ready=1 again.
- Issue rd=9 and EXU writeback to rd=9 in the same cycle, starting from count 1:
  - Required: count stays 1 and o_stall stays 1 for rs2=9.
- Writeback to rd=0 with data=0x1234:
  - Required: handshake completes, o_rf_wen=0, no stall change.
- Assert i_rst with an outstanding grant:
  - Required: next cycle o_rf_wen=0 and all stalls 0.
